// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers functional-unit results per source and broadcasts up to two per cycle pair on the CDB.
//
// Ports
//   clock                 rising-edge clock
//   reset                 asynchronous, active-high reset
//   src_valid[NUM_SRC]    per-source result strobe (one result per sampled-high edge)
//   src_rob / src_data    per-source ROB tag / result, slice k = [k*W +: W]
//   stall                 1 = no new grants
//   src_full[NUM_SRC]     FIFO k holds FIFO_DEPTH entries
//   overflow              sticky: a write was dropped because its FIFO was full
//   CDBiscast/CDBrobNum/CDBdata       channel-1 strobe, tag, data
//   CDBiscast2/CDBrobNum2/CDBdata2    channel-2 strobe, tag, data
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_W = 6,
  parameter int DATA_W = 32,
  parameter logic [ROB_W-1:0] INVALID_ROB = 6'd16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]  src_rob,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      stall,
  output logic [NUM_SRC-1:0]        src_full,
  output logic                      overflow,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2
);
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, CAST} state_t;
  state_t state;
  logic [ROB_W-1:0] mem_rob [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0] head [NUM_SRC];
  logic [PW-1:0] tail [NUM_SRC];
  logic [CW-1:0] count [NUM_SRC];
  logic [SW-1:0] rr_ptr, g1, g2, idx, last;
  logic g1v, g2v, go;
  logic [NUM_SRC-1:0] push, pop;
  // full is judged on the pre-edge count, so a same-edge pop never frees room for a write
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_full[i] = count[i] == CW'(FIFO_DEPTH);
    assign push[i] = src_valid[i] && !src_full[i];
    assign pop[i] = go && ((g1v && g1 == SW'(i)) || (g2v && g2 == SW'(i)));
  end
  // round-robin scan starting at rr_ptr: first non-empty source to ch1, second to ch2
  always_comb begin
    g1v = 1'b0;
    g2v = 1'b0;
    g1 = '0;
    g2 = '0;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = SW'((int'(rr_ptr) + i) % NUM_SRC);
      if (count[idx] != '0) begin
        if (!g1v) begin
          g1v = 1'b1;
          g1 = idx;
        end else if (!g2v) begin
          g2v = 1'b1;
          g2 = idx;
        end
      end
    end
  end
  assign go = state == IDLE && !stall && g1v;
  assign last = g2v ? g2 : g1;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        head[k] <= '0;
        tail[k] <= '0;
        count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (push[k]) tail[k] <= tail[k] + PW'(1);
        if (pop[k]) head[k] <= head[k] + PW'(1);
        count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
      end
    end
  end
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (push[k]) begin
        mem_rob[k][tail[k]] <= src_rob[k*ROB_W +: ROB_W];
        mem_data[k][tail[k]] <= src_data[k*DATA_W +: DATA_W];
      end
    end
  end
  // tags/data are held through CAST so consumers see them stable across the strobe fall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      overflow <= 1'b0;
      CDBiscast <= 1'b0;
      CDBrobNum <= INVALID_ROB;
      CDBdata <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_ROB;
      CDBdata2 <= '0;
    end else begin
      overflow <= overflow | (|(src_valid & src_full));
      if (state == CAST) begin
        CDBiscast <= 1'b0;
        CDBiscast2 <= 1'b0;
        state <= IDLE;
      end else if (go) begin
        CDBiscast <= 1'b1;
        CDBrobNum <= mem_rob[g1][head[g1]];
        CDBdata <= mem_data[g1][head[g1]];
        CDBiscast2 <= g2v;
        CDBrobNum2 <= g2v ? mem_rob[g2][head[g2]] : INVALID_ROB;
        CDBdata2 <= g2v ? mem_data[g2][head[g2]] : '0;
        rr_ptr <= last == SW'(NUM_SRC - 1) ? '0 : last + SW'(1);
        state <= CAST;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus randomized checking of cdb_arbiter against a queue-based model.
module tb_cdb_arbiter;
  logic clock = 0;
  logic reset = 1;
  logic [3:0] src_valid;
  logic [23:0] src_rob;
  logic [127:0] src_data;
  logic stall;
  logic [3:0] src_full;
  logic overflow;
  logic CDBiscast, CDBiscast2;
  logic [5:0] CDBrobNum, CDBrobNum2;
  logic [31:0] CDBdata, CDBdata2;
  int checks = 0;
  int errors = 0;
  cdb_arbiter dut (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_rob(src_rob),
    .src_data(src_data), .stall(stall), .src_full(src_full), .overflow(overflow),
    .CDBiscast(CDBiscast), .CDBrobNum(CDBrobNum), .CDBdata(CDBdata),
    .CDBiscast2(CDBiscast2), .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: one queue per source, outputs recomputed each edge from pre-edge occupancy
  logic [37:0] q [4][$];
  logic [37:0] ent;
  int sz [4];
  int g [$];
  int rr, mk;
  bit m_cast;
  logic e_s1 = 0, e_s2 = 0, e_ovf = 0;
  logic [5:0] e_rob1 = 16, e_rob2 = 16;
  logic [31:0] e_d1 = 0, e_d2 = 0;
  logic [3:0] e_full;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      rr = 0;
      m_cast = 0;
      e_s1 = 0;
      e_s2 = 0;
      e_rob1 = 16;
      e_rob2 = 16;
      e_d1 = 0;
      e_d2 = 0;
      e_ovf = 0;
    end else begin
      for (int i = 0; i < 4; i++) sz[i] = q[i].size();
      g.delete();
      if (!m_cast && !stall)
        for (int i = 0; i < 4; i++) begin
          mk = (rr + i) % 4;
          if (sz[mk] > 0 && g.size() < 2) g.push_back(mk);
        end
      if (g.size() > 0) begin
        ent = q[g[0]].pop_front();
        e_s1 = 1;
        e_rob1 = ent[37:32];
        e_d1 = ent[31:0];
        if (g.size() == 2) begin
          ent = q[g[1]].pop_front();
          e_s2 = 1;
          e_rob2 = ent[37:32];
          e_d2 = ent[31:0];
        end else begin
          e_s2 = 0;
          e_rob2 = 16;
          e_d2 = 0;
        end
        rr = (g[g.size()-1] + 1) % 4;
        m_cast = 1;
      end else if (m_cast) begin
        e_s1 = 0;
        e_s2 = 0;
        m_cast = 0;
      end
      for (int i = 0; i < 4; i++)
        if (src_valid[i]) begin
          if (sz[i] < 4) q[i].push_back({src_rob[i*6 +: 6], src_data[i*32 +: 32]});
          else e_ovf = 1;
        end
    end
  end
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) e_full[i] = q[i].size() == 4;
    chk("cast1", CDBiscast, e_s1);
    chk("rob1", CDBrobNum, e_rob1);
    chk("data1", CDBdata, e_d1);
    chk("cast2", CDBiscast2, e_s2);
    chk("rob2", CDBrobNum2, e_rob2);
    chk("data2", CDBdata2, e_d2);
    chk("src_full", src_full, e_full);
    chk("overflow", overflow, e_ovf);
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic set_src(input int k, input logic [5:0] r, input logic [31:0] d);
    src_valid[k] = 1;
    src_rob[k*6 +: 6] = r;
    src_data[k*32 +: 32] = d;
  endtask
  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask
  initial begin
    stall = 0;
    src_valid = 0;
    src_rob = 0;
    src_data = 0;
    step();
    step();
    chk("rst_cast1", CDBiscast, 0);
    chk("rst_rob1", CDBrobNum, 16);
    chk("rst_rob2", CDBrobNum2, 16);
    chk("rst_full", src_full, 0);
    reset = 0;
    step();
    set_src(0, 5, 1);
    step();
    src_valid = 0;
    chk("single_early", CDBiscast, 0);
    step();
    chk("single_cast1", CDBiscast, 1);
    chk("single_rob1", CDBrobNum, 5);
    chk("single_data1", CDBdata, 1);
    chk("single_cast2", CDBiscast2, 0);
    chk("single_rob2", CDBrobNum2, 16);
    chk("model_rob1", e_rob1, 5);
    step();
    chk("single_fall", CDBiscast, 0);
    chk("single_hold", CDBrobNum, 5);
    step();
    set_src(0, 1, 11);
    step();
    set_src(0, 2, 12);
    step();
    chk("order_c1", CDBiscast, 1);
    chk("order_r1", CDBrobNum, 1);
    set_src(0, 3, 13);
    step();
    src_valid = 0;
    chk("order_gap1", CDBiscast, 0);
    for (int n = 2; n <= 3; n++) begin
      step();
      chk("order_cast", CDBiscast, 1);
      chk("order_rob", CDBrobNum, 6'(n));
      chk("order_no2", CDBiscast2, 0);
      step();
      chk("order_gap", CDBiscast, 0);
    end
    do_reset();
    stall = 1;
    for (int k = 0; k < 4; k++) set_src(k, 6'(20 + k), 100 + k);
    step();
    for (int k = 0; k < 4; k++) set_src(k, 6'(24 + k), 200 + k);
    step();
    src_valid = 0;
    stall = 0;
    chk("rr_no_full", src_full, 0);
    for (int p = 0; p < 4; p++) begin
      step();
      chk("rr_cast1", CDBiscast, 1);
      chk("rr_rob1", CDBrobNum, 6'(20 + 2 * p));
      chk("rr_cast2", CDBiscast2, 1);
      chk("rr_rob2", CDBrobNum2, 6'(21 + 2 * p));
      step();
      chk("rr_gap", CDBiscast | CDBiscast2, 0);
    end
    stall = 1;
    for (int n = 0; n < 5; n++) begin
      set_src(3, 6'(8 + n), 300 + n);
      step();
      if (n == 3) begin
        chk("ovf_full", src_full, 4'b1000);
        chk("ovf_not_yet", overflow, 0);
      end
      if (n == 4) chk("ovf_set", overflow, 1);
    end
    src_valid = 0;
    stall = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("ovf_cast", CDBiscast, 1);
      chk("ovf_rob", CDBrobNum, 6'(8 + n));
      chk("ovf_no2", CDBiscast2, 0);
      step();
    end
    step();
    step();
    chk("ovf_drained", CDBiscast, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_empty", src_full, 0);
    set_src(0, 9, 9);
    step();
    src_valid = 0;
    step();
    chk("midcast_high", CDBiscast, 1);
    #2 reset = 1;
    #1;
    chk("async_cast1", CDBiscast, 0);
    chk("async_cast2", CDBiscast2, 0);
    chk("async_rob1", CDBrobNum, 16);
    chk("async_rob2", CDBrobNum2, 16);
    chk("async_data1", CDBdata, 0);
    chk("async_ovf", overflow, 0);
    chk("async_full", src_full, 0);
    step();
    reset = 0;
    step();
    set_src(1, 3, 32'hA);
    set_src(2, 7, 32'hB);
    step();
    src_valid = 0;
    step();
    chk("pair_cast1", CDBiscast, 1);
    chk("pair_rob1", CDBrobNum, 3);
    chk("pair_data1", CDBdata, 32'hA);
    chk("pair_cast2", CDBiscast2, 1);
    chk("pair_rob2", CDBrobNum2, 7);
    chk("pair_data2", CDBdata2, 32'hB);
    set_src(0, 40, 0);
    set_src(3, 43, 0);
    step();
    src_valid = 0;
    chk("pair_gap", CDBiscast, 0);
    step();
    chk("rr3_rob1", CDBrobNum, 43);
    chk("rr3_rob2", CDBrobNum2, 40);
    chk("rr3_cast2", CDBiscast2, 1);
    repeat (3000) begin
      step();
      stall = $urandom_range(0, 7) == 0;
      for (int k = 0; k < 4; k++) src_valid[k] = $urandom_range(0, 3) == 0;
      src_rob = 24'($urandom);
      src_data = {$urandom, $urandom, $urandom, $urandom};
    end
    src_valid = 0;
    stall = 0;
    repeat (40) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
